fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID output register; sits directly upstream of the decode stage and supplies its Instruction and PC+4.
- Owns the PC and issues one outstanding request at a time to a variable-latency instruction memory using a req/ack handshake.
- Honours freeze from hazard detection through a one-entry skid buffer, and branch redirect/flush from EXE.
- Branch has priority over freeze.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  hazard stall; hold the IF/ID output register.
- branch_taken  in  1  redirect from EXE; flush the fetch path.
- branch_addr  in  32  redirect target; bits [1:0] forced to 0.
- imem_req  out  1  fetch request; held high until acked.
- imem_addr  out  32  word-aligned fetch address; stable while imem_req is high and not acked.
- imem_ack  in  1  one-cycle pulse; imem_rdata is valid this cycle; may arrive in the same cycle req is first raised.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  if_instruction/if_pc hold a real instruction.
- if_instruction  out  32  to decode stage.
- if_pc  out  32  fetch address + 4, to decode stage.

Behaviour:
- Reset (async, rst=0):
  - pc=RESET_PC, state=FETCH, skid empty, target=0.
  - if_valid=0, if_instruction=0, if_pc=0.
  - imem_req forced 0 while rst=0. First request is in the first cycle after release.
- Registers: pc (current request address), target (pending redirect), skid {instr, pc4}, output register {if_valid, if_instruction, if_pc}.
- Combinational outputs:
  - imem_addr = pc.
  - imem_req = 1 in FETCH and DISCARD; 0 in STALL.
- Address arithmetic: pc+4 is 32-bit, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- FETCH:
  - ack & branch_taken: drop rdata; pc<=branch_addr; if_valid<=0; stay in FETCH. The new request is issued next cycle.
  - ack & !freeze: output<={1, rdata, pc+4}; pc<=pc+4. Zero-bubble streaming when memory acks every cycle.
  - ack & freeze: skid<={rdata, pc+4}; pc<=pc+4; output held; go to STALL.
  - !ack & branch_taken: target<=branch_addr; if_valid<=0; go to DISCARD. The request in flight cannot be aborted, so imem_addr stays at the old pc.
  - !ack & !freeze: if_valid<=0 (bubble); instruction/pc fields are don't-care, but hold them.
  - !ack & freeze: output held.
- DISCARD:
  - Request stays high at the old address.
  - A further branch_taken updates target (latest wins) and keeps if_valid=0.
  - On ack: rdata dropped; pc<=target (or branch_addr if branch_taken in the same cycle); go to FETCH.
  - freeze is ignored; if_valid stays 0.
- STALL:
  - No request is issued.
  - branch_taken: skid discarded; pc<=branch_addr; if_valid<=0; go to FETCH.
  - !freeze: output<={1, skid}; go to FETCH.
  - freeze: hold.
- Output ordering invariant: instructions leave in fetch order, with no duplicates and no losses. Every acked word is delivered exactly once unless it is flushed by a branch.
- Reset mid-transaction: state returns to reset values immediately. Any ack that arrives while rst=0 or in the first cycle after release with no request issued is ignored.
- An ack seen while imem_req=0 is a protocol error. It is ignored; an assertion flags it.

Decomposition:
- Shared package (pipeline package):
  - fetch state enum {FETCH, DISCARD, STALL}.
  - WORD_BYTES=4.
  - NOP instruction constant, used for verification display only.
- One natural sub-module: fetch_skid_buffer, a one-entry {instr, pc4} register with load, unload and flush controls and a full flag. All remaining logic (FSM, pc, target, output register) stays in fetch_stage.

Test Plan:
- Reset and stream: memory acks every cycle with rdata=addr^32'hA5A5_0000 after rst release. Required: if_pc sequence 4, 8, 12…; if_valid=1 from the 2nd cycle; imem_addr 0, 4, 8 back-to-back.
- Freeze on ack: freeze=1 for 3 cycles, asserted in the cycle the word at addr 8 is acked. Required: output holds addr-4 data; imem_req=0 for the stall cycles; after release if_pc=12 with the addr-8 word; no loss, no duplicate.
- Branch during outstanding fetch: 3-cycle-latency memory; branch_taken with branch_addr=32'h100 one cycle after req to 0x10. Required: imem_addr stays 0x10 until ack; that data is dropped; next request is 0x100; if_valid=0 until the 0x100 word arrives (if_pc=0x104).
- Branch during STALL: skid full, freeze=1, branch_taken with branch_addr=32'h203. Required: skid flushed; if_valid=0; next imem_addr=32'h200.
- Wrap-around: RESET_PC=32'hFFFF_FFF8. Required: fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; if_pc of the second word is 0.
- Async reset mid-DISCARD: rst=0 while waiting for ack. Required: imem_req=0 and if_valid=0 immediately (no clock edge); after release the first imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared pipeline definitions for the fetch stage: FSM states, word size and the NOP encoding.
package fetch_pkg;
  typedef enum logic [1:0] {FETCH, DISCARD, STALL} fetch_state_e;
  localparam int unsigned WORD_BYTES = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc4} holding register that catches a word acked while decode is frozen.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        flush,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc4_d,
  output logic [31:0] instr_q,
  output logic [31:0] pc4_q,
  output logic        full
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full    <= 1'b0;
      instr_q <= '0;
      pc4_q   <= '0;
    end else if (flush || unload) begin
      full <= 1'b0;
    end else if (load) begin
      full    <= 1'b1;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with one outstanding req/ack memory request, freeze skid and branch redirect,
// feeding the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc
);
  fetch_state_e state;
  logic [31:0]  pc, target;
  logic [31:0]  pc4, br_tgt;
  logic         skid_load, skid_unload, skid_flush, skid_full;
  logic [31:0]  skid_instr, skid_pc4;

  assign pc4       = pc + 32'(WORD_BYTES);
  assign br_tgt    = branch_addr & ~32'h3;
  assign imem_addr = pc;
  assign imem_req  = rst && (state != STALL);

  assign skid_load   = (state == FETCH) && imem_ack && !branch_taken && freeze;
  assign skid_unload = (state == STALL) && !branch_taken && !freeze;
  assign skid_flush  = (state == STALL) && branch_taken;

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .unload  (skid_unload),
    .flush   (skid_flush),
    .instr_d (imem_rdata),
    .pc4_d   (pc4),
    .instr_q (skid_instr),
    .pc4_q   (skid_pc4),
    .full    (skid_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      target         <= '0;
      if_valid       <= 1'b0;
      if_instruction <= '0;
      if_pc          <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ack) begin
            if (branch_taken) begin
              pc       <= br_tgt;
              if_valid <= 1'b0;
            end else if (!freeze) begin
              if_valid       <= 1'b1;
              if_instruction <= imem_rdata;
              if_pc          <= pc4;
              pc             <= pc4;
            end else begin
              pc    <= pc4;
              state <= STALL;
            end
          end else if (branch_taken) begin
            // The in-flight request cannot be aborted; remember where to go once it lands.
            target   <= br_tgt;
            if_valid <= 1'b0;
            state    <= DISCARD;
          end else if (!freeze) begin
            if_valid <= 1'b0;
          end
        end
        DISCARD: begin
          if_valid <= 1'b0;
          if (imem_ack) begin
            pc    <= branch_taken ? br_tgt : target;
            state <= FETCH;
          end else if (branch_taken) begin
            target <= br_tgt;
          end
        end
        STALL: begin
          if (branch_taken) begin
            pc       <= br_tgt;
            if_valid <= 1'b0;
            state    <= FETCH;
          end else if (!freeze) begin
            if_valid       <= 1'b1;
            if_instruction <= skid_instr;
            if_pc          <= skid_pc4;
            state          <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  ack_without_req: assert property (@(posedge clk) disable iff (!rst) imem_ack |-> imem_req);
  stall_has_word:  assert property (@(posedge clk) disable iff (!rst) (state == STALL) |-> skid_full);
endmodule
